// File: rtl/full_adder.sv
// Single-bit full adder with zero-latency outputs, a registered copy of the
// result, and a sticky record of which {Cin,B,A} combinations have been sampled.
module full_adder (
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  input  logic       Cin,
  output logic       Sum,
  output logic       Cout,
  output logic       Sum_q,
  output logic       Cout_q,
  output logic [7:0] Seen,
  output logic       AllSeen
);

  logic [2:0] combo;
  logic       sum_d;
  logic       cout_d;
  logic [7:0] seen_d;
  logic [7:0] seen_q;

  assign combo  = {Cin, B, A};
  assign sum_d  = A ^ B ^ Cin;
  assign cout_d = (A & B) | (A & Cin) | (B & Cin);

  // The ripple-carry cell and the shadow registers share one set of gates.
  assign Sum  = sum_d;
  assign Cout = cout_d;

  always_comb begin
    // NOTE: default first so every path assigns seen_d and no latch is inferred.
    seen_d        = seen_q;
    seen_d[combo] = 1'b1;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Sum_q  <= 1'b0;
      Cout_q <= 1'b0;
      seen_q <= 8'h00;
    end else begin
      Sum_q  <= sum_d;
      Cout_q <= cout_d;
      seen_q <= seen_d;
    end
  end

  assign Seen    = seen_q;
  assign AllSeen = &seen_q;

endmodule

// File: tb/tb_full_adder.sv
// Directed and random checks of full_adder: combinational truth table, register
// latency, coverage mask growth, asynchronous reset and between-edge glitches.
module tb_full_adder;

  logic       clk;
  logic       reset;
  logic       A;
  logic       B;
  logic       Cin;
  logic       Sum;
  logic       Cout;
  logic       Sum_q;
  logic       Cout_q;
  logic [7:0] Seen;
  logic       AllSeen;

  int checks;
  int errors;

  // Hand-computed {Cout,Sum} for each {Cin,B,A} index.
  logic [1:0] exp_tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
  // Coverage order for the growth test: every combination once.
  int         order  [8] = '{3, 5, 0, 6, 1, 7, 2, 4};
  // Sequence leaving Seen = 8'h3F with combination 100 last, so Sum_q = 1.
  int         pre    [6] = '{0, 1, 2, 3, 5, 4};

  full_adder dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .Cin    (Cin),
    .Sum    (Sum),
    .Cout   (Cout),
    .Sum_q  (Sum_q),
    .Cout_q (Cout_q),
    .Seen   (Seen),
    .AllSeen(AllSeen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int c);
    logic [2:0] v;
    v   = 3'(c);
    A   = v[0];
    B   = v[1];
    Cin = v[2];
  endtask

  // One full clock period; outputs are checked afterwards with clk low.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic pulse_reset();
    #1 reset = 1'b1;
    #3 reset = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] exp_mask;
    logic [1:0] exp_val;
    int         r;
    checks = 0;
    errors = 0;
    clk    = 1'b0;
    reset  = 1'b1;
    A      = 1'b0;
    B      = 1'b0;
    Cin    = 1'b0;
    #2;
    check("reset_sum_q",   Sum_q,   0);
    check("reset_cout_q",  Cout_q,  0);
    check("reset_seen",    Seen,    8'h00);
    check("reset_allseen", AllSeen, 0);

    // Combinational sweep with the clock idle and reset still high.
    for (int c = 0; c < 8; c++) begin
      drive(c);
      #10;
      check($sformatf("comb_%0d", c), {Cout, Sum}, exp_tt[c]);
    end
    reset = 1'b0;
    #1;

    // Registered latency: 000 then 111.
    pulse_reset();
    drive(0);
    tick();
    check("lat_000_sum_q",  Sum_q,  0);
    check("lat_000_cout_q", Cout_q, 0);
    drive(7);
    tick();
    check("lat_111_sum_q",  Sum_q,  1);
    check("lat_111_cout_q", Cout_q, 1);

    // Coverage growth, one new bit per edge.
    pulse_reset();
    exp_mask = 8'h00;
    for (int i = 0; i < 8; i++) begin
      drive(order[i]);
      tick();
      exp_mask[order[i]] = 1'b1;
      check($sformatf("cov_seen_%0d", i),    Seen,    exp_mask);
      check($sformatf("cov_allseen_%0d", i), AllSeen, (i == 7));
    end
    drive(3);
    tick();
    check("cov_repeat_seen",    Seen,    8'hFF);
    check("cov_repeat_allseen", AllSeen, 1);

    // Asynchronous reset between edges.
    pulse_reset();
    for (int i = 0; i < 6; i++) begin
      drive(pre[i]);
      tick();
    end
    check("ar_pre_seen",  Seen,  8'h3F);
    check("ar_pre_sum_q", Sum_q, 1);
    drive(3);
    #2 reset = 1'b1;
    #1;
    check("ar_seen",    Seen,    8'h00);
    check("ar_sum_q",   Sum_q,   0);
    check("ar_cout_q",  Cout_q,  0);
    check("ar_allseen", AllSeen, 0);
    check("ar_comb_011", {Cout, Sum}, 2'b10);
    drive(7);
    #1;
    check("ar_comb_111", {Cout, Sum}, 2'b11);
    reset = 1'b0;
    drive(2);
    #1;
    tick();
    check("ar_post_seen",   Seen,   8'h04);
    check("ar_post_sum_q",  Sum_q,  1);
    check("ar_post_cout_q", Cout_q, 0);

    // Glitch: 001 -> 110 -> 001 before a single edge.
    pulse_reset();
    drive(1);
    #1 drive(6);
    #1 drive(1);
    tick();
    check("glitch_seen",   Seen,   8'h02);
    check("glitch_sum_q",  Sum_q,  1);
    check("glitch_cout_q", Cout_q, 0);

    // Random vectors, one per cycle.
    pulse_reset();
    for (int i = 0; i < 1000; i++) begin
      r = int'($urandom_range(0, 7));
      drive(r);
      #1;
      exp_val = 2'(A) + 2'(B) + 2'(Cin);
      check("rand_comb", {Cout, Sum}, exp_val);
      tick();
      check("rand_reg", {Cout_q, Sum_q}, exp_val);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
